// File: rtl/aes_apb_requester_if.sv
// Bundles the command/response handshake and the APB requester bus of aes_apb_requester.
// master: the requester's view; slave: the command source plus APB completer side.
`timescale 1ns/1ps
interface aes_apb_requester_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] aps_m0_paddr;
  logic              aps_m0_psel;
  logic              aps_m0_penable;
  logic              aps_m0_pwrite;
  logic [DATA_W-1:0] aps_m0_pwdata;
  logic [DATA_W-1:0] aps_m0_prdata;
  logic              aps_m0_pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, aps_m0_prdata, aps_m0_pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           aps_m0_paddr, aps_m0_psel, aps_m0_penable, aps_m0_pwrite, aps_m0_pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, aps_m0_prdata, aps_m0_pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           aps_m0_paddr, aps_m0_psel, aps_m0_penable, aps_m0_pwrite, aps_m0_pwdata
  );
endinterface

// File: rtl/aes_apb_requester.sv
// APB requester for the AES register block: turns one valid/ready command into one
// SETUP/ACCESS transfer and returns one response strobe, aborting stalls after a timeout.
`timescale 1ns/1ps
module aes_apb_requester #(
  parameter int          ADDR_W         = 4,
  parameter int          DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   clock_clk,
  input  logic                   reset_reset_n,
  aes_apb_requester_if.master    bus,
  output logic [1:0]             state_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // Handshake: a command is taken on a rising edge where cmd_valid and cmd_ready are both
  // high; cmd_ready is high only in IDLE. rsp_valid is a single-cycle strobe with no ready.
  logic [1:0]        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              timeout_hit;

  // The abort fires on the ACCESS cycle that would be the TIMEOUT_CYCLES-th wait.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    wait_cnt_d    = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          paddr_d     = bus.cmd_addr;
          pwrite_d    = bus.cmd_write;
          pwdata_d    = bus.cmd_wdata;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b0;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.aps_m0_pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : bus.aps_m0_prdata;
          state_d       = ST_RESP;
        end else if (timeout_hit) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          wait_cnt_d    = wait_cnt_q + CNT_W'(1);
          state_d       = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        wait_cnt_d    = '0;
        cmd_ready_d   = 1'b1;
        state_d       = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_timeout    = rsp_timeout_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.aps_m0_paddr   = paddr_q;
  assign bus.aps_m0_psel    = psel_q;
  assign bus.aps_m0_penable = penable_q;
  assign bus.aps_m0_pwrite  = pwrite_q;
  assign bus.aps_m0_pwdata  = pwdata_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_aes_apb_requester.sv
// Bench for aes_apb_requester: directed commands, response scoreboard, APB transfer monitor.
// u_dut uses the 16-cycle timeout; u_dut_nt has the timeout disabled.
`timescale 1ns/1ps
module tb_aes_apb_requester;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_apb_requester_if #(.ADDR_W(4), .DATA_W(32)) bus0 ();
  aes_apb_requester_if #(.ADDR_W(4), .DATA_W(32)) bus1 ();
  logic [1:0] state0, state1;

  aes_apb_requester #(.ADDR_W(4), .DATA_W(32), .TIMEOUT_CYCLES(16)) u_dut (
    .clock_clk(clk), .reset_reset_n(rst_n), .bus(bus0), .state_o(state0));

  aes_apb_requester #(.ADDR_W(4), .DATA_W(32), .TIMEOUT_CYCLES(0)) u_dut_nt (
    .clock_clk(clk), .reset_reset_n(rst_n), .bus(bus1), .state_o(state1));

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {timeout, rdata, response cycle}
  logic [64:0] exp_q[$];
  logic [64:0] exp1_q[$];
  // {setup cycle, pwrite, paddr, pwdata}
  logic [68:0] exp_apb_q[$];
  logic [36:0] hold0;

  // ---------------- APB completer model for bus0 ----------------
  int          pr_mode = 0;      // 0: pready tied 1, 1: wait states, 2: never ready
  int          wait_states = 0;
  logic [31:0] rd_value = 32'h0;
  int          acc_cnt = 0;

  always_comb begin
    bus0.aps_m0_pready = 1'b0;
    if (pr_mode == 0)
      bus0.aps_m0_pready = 1'b1;
    else if (pr_mode == 1)
      bus0.aps_m0_pready = bus0.aps_m0_psel && bus0.aps_m0_penable && (acc_cnt >= wait_states);
  end
  assign bus0.aps_m0_prdata = rd_value;

  always @(posedge clk) begin
    if (bus0.aps_m0_psel && bus0.aps_m0_penable && !bus0.aps_m0_pready)
      acc_cnt <= acc_cnt + 1;
    else
      acc_cnt <= 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n && bus0.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp0_unexpected", 64'd1, 64'd0);
      end else begin
        check("rsp0_timeout", 64'(bus0.rsp_timeout), 64'(exp_q[0][64]));
        check("rsp0_rdata", 64'(bus0.rsp_rdata), 64'(exp_q[0][63:32]));
        check("rsp0_cycle", 64'(cyc), 64'(exp_q[0][31:0]));
        check("rsp0_bus_released", 64'({bus0.aps_m0_psel, bus0.aps_m0_penable}), 64'd0);
        void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus1.rsp_valid) begin
      if (exp1_q.size() == 0) begin
        check("rsp1_unexpected", 64'd1, 64'd0);
      end else begin
        check("rsp1_timeout", 64'(bus1.rsp_timeout), 64'(exp1_q[0][64]));
        check("rsp1_rdata", 64'(bus1.rsp_rdata), 64'(exp1_q[0][63:32]));
        check("rsp1_cycle", 64'(cyc), 64'(exp1_q[0][31:0]));
        void'(exp1_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus0.aps_m0_psel && !bus0.aps_m0_penable) begin
      if (exp_apb_q.size() == 0) begin
        check("apb_unexpected_setup", 64'd1, 64'd0);
      end else begin
        check("apb_setup_cycle", 64'(cyc), 64'(exp_apb_q[0][68:37]));
        check("apb_setup_fields",
              64'({bus0.aps_m0_pwrite, bus0.aps_m0_paddr, bus0.aps_m0_pwdata}),
              64'(exp_apb_q[0][36:0]));
        void'(exp_apb_q.pop_front());
      end
      hold0 <= {bus0.aps_m0_pwrite, bus0.aps_m0_paddr, bus0.aps_m0_pwdata};
    end else if (rst_n && bus0.aps_m0_psel && bus0.aps_m0_penable) begin
      check("apb_access_hold",
            64'({bus0.aps_m0_pwrite, bus0.aps_m0_paddr, bus0.aps_m0_pwdata}), 64'(hold0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                       input logic to, input logic [31:0] rdata, input int lat,
                       input bit exp_rsp, input bit hold, output int acc);
    int n;
    @(negedge clk);
    bus0.cmd_write = wr;
    bus0.cmd_addr  = addr;
    bus0.cmd_wdata = wdata;
    bus0.cmd_valid = 1'b1;
    n = 0;
    while (!bus0.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!bus0.cmd_ready) begin
      check("accept_wait", 64'd0, 64'd1);
      bus0.cmd_valid = 1'b0;
      return;
    end
    exp_apb_q.push_back({32'(acc + 1), wr, addr, wdata});
    if (exp_rsp) exp_q.push_back({to, rdata, 32'(acc + lat)});
    @(posedge clk);
    #1;
    if (!hold) bus0.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus0.cmd_ready && exp_q.size() == 0) && n < 500);
    if (n >= 500) check("idle_wait", 64'd0, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  int acc, prev_acc, n;

  initial begin
    rst_n = 1'b0;
    bus0.cmd_valid = 1'b0; bus0.cmd_write = 1'b0; bus0.cmd_addr = '0; bus0.cmd_wdata = '0;
    bus1.cmd_valid = 1'b0; bus1.cmd_write = 1'b0; bus1.cmd_addr = '0; bus1.cmd_wdata = '0;
    bus1.aps_m0_pready = 1'b0; bus1.aps_m0_prdata = '0;
    repeat (3) @(negedge clk);
    check("rst_psel", 64'(bus0.aps_m0_psel), 64'd0);
    check("rst_penable", 64'(bus0.aps_m0_penable), 64'd0);
    check("rst_rsp_valid", 64'(bus0.rsp_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 64'(bus0.cmd_ready), 64'd1);
    check("post_rst_state", 64'(state0), 64'd0);
    check("post_rst_bus", 64'({bus0.aps_m0_pwrite, bus0.aps_m0_paddr, bus0.aps_m0_pwdata}), 64'd0);
    check("post_rst_rsp", 64'({bus0.rsp_timeout, bus0.rsp_rdata}), 64'd0);

    // Write, zero wait (pready already high during SETUP)
    pr_mode = 0;
    issue(1'b1, 4'h4, 32'h0011_2233, 1'b0, 32'h0, 3, 1'b1, 1'b0, acc);
    repeat (3) @(negedge clk);
    check("w0_ready_in_resp", 64'(bus0.cmd_ready), 64'd0);
    @(negedge clk);
    check("w0_ready_again", 64'(bus0.cmd_ready), 64'd1);
    check("w0_idle_hold", 64'({bus0.aps_m0_pwrite, bus0.aps_m0_paddr, bus0.aps_m0_pwdata}),
          64'({1'b1, 4'h4, 32'h0011_2233}));

    // Read with three wait states
    pr_mode = 1; wait_states = 3; rd_value = 32'hDEAD_BEEF;
    issue(1'b0, 4'hC, 32'h0, 1'b0, 32'hDEAD_BEEF, 6, 1'b1, 1'b0, acc);
    wait_idle();
    repeat (3) @(negedge clk);
    check("rdata_hold_idle", 64'(bus0.rsp_rdata), 64'hDEAD_BEEF);

    // Timeout after 16 stalled ACCESS cycles, then a normal command
    pr_mode = 2;
    issue(1'b0, 4'h8, 32'h0, 1'b1, 32'h0, 18, 1'b1, 1'b0, acc);
    wait_idle();
    pr_mode = 0;
    issue(1'b1, 4'h0, 32'hA5A5_5A5A, 1'b0, 32'h0, 3, 1'b1, 1'b0, acc);
    wait_idle();

    // Back-to-back plaintext writes with cmd_valid held; later commands wait for IDLE
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 4'(i * 4), 32'h1000_0000 + 32'(i), 1'b0, 32'h0, 3, 1'b1, (i < 3), acc);
      if (i > 0) check("b2b_spacing", 64'(acc - prev_acc), 64'd4);
      prev_acc = acc;
    end
    wait_idle();

    // Reset during ACCESS: no response for the aborted read
    pr_mode = 2;
    issue(1'b0, 4'h4, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0, acc);
    n = 0;
    while (!bus0.aps_m0_penable && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_access", 64'(bus0.aps_m0_penable), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_psel", 64'(bus0.aps_m0_psel), 64'd0);
    check("rst_mid_penable", 64'(bus0.aps_m0_penable), 64'd0);
    check("rst_mid_rsp_valid", 64'(bus0.rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pr_mode = 0;
    @(negedge clk);
    check("rst_mid_cmd_ready", 64'(bus0.cmd_ready), 64'd1);
    repeat (20) @(negedge clk);
    rd_value = 32'h0BAD_F00D;
    issue(1'b0, 4'h4, 32'h0, 1'b0, 32'h0BAD_F00D, 3, 1'b1, 1'b0, acc);
    wait_idle();

    // Timeout disabled: 100 stalled ACCESS cycles then completion
    @(negedge clk);
    bus1.cmd_write = 1'b0; bus1.cmd_addr = 4'hC; bus1.cmd_wdata = '0; bus1.cmd_valid = 1'b1;
    n = 0;
    while (!bus1.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    exp1_q.push_back({1'b0, 32'hCAFE_F00D, 32'(acc + 103)});
    @(posedge clk);
    #1 bus1.cmd_valid = 1'b0;
    n = 0;
    while (!bus1.aps_m0_penable && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (100) @(negedge clk);
    check("nt_no_abort", 64'({bus1.aps_m0_psel, bus1.aps_m0_penable}), 64'd3);
    bus1.aps_m0_pready = 1'b1;
    bus1.aps_m0_prdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus1.aps_m0_pready = 1'b0;
    repeat (3) @(negedge clk);

    wait_idle();
    check("queues_drained", 64'(exp_q.size() + exp1_q.size() + exp_apb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
